// File: rtl/sdr_ddr_pack.sv
// ---------------------------------------------------------------------------
// sdr_ddr_pack
// SDR-domain transmit packer for the SDR-to-DDR output mux. A valid/ready
// stream of up to two beats per clk_sdr_i cycle is buffered in a small FIFO.
// Each SDR cycle the packer issues one registered two-slot word. Slot0 goes
// out in the first DDR half-cycle and slot1 in the second. Bursts are framed
// with an output enable and a single postamble cycle. Protocol errors are
// recorded in sticky flags.
//
// Ports
//   clk_sdr_i   SDR clock, rising edge
//   rst_sdr_ni  asynchronous active-low reset
//   s_data_i    input word, lane0 [DW-1:0] is earlier than lane1
//   s_keep_i    lane valid (01 / 11 legal, 10 illegal, 00 empty)
//   s_last_i    highest kept lane ends the burst
//   s_valid_i   input word valid
//   s_ready_o   input accepted when valid && ready
//   m_data_o    output word, slot0 [DW-1:0] first, slot1 second
//   m_keep_o    slot valid
//   m_en_o      burst active (pad output enable)
//   fill_o      FIFO level in beats
//   err_o       sticky errors: [0] illegal keep, [1] underrun
//   err_clr_i   clears err_o (a simultaneous set wins)
// ---------------------------------------------------------------------------
module sdr_ddr_pack #(
   parameter int DW        = 8,
   parameter int DEPTH     = 16,
   parameter int START_LVL = 4
) (
   input  logic                       clk_sdr_i,
   input  logic                       rst_sdr_ni,
   input  logic [2*DW-1:0]            s_data_i,
   input  logic [1:0]                 s_keep_i,
   input  logic                       s_last_i,
   input  logic                       s_valid_i,
   output logic                       s_ready_o,
   output logic [2*DW-1:0]            m_data_o,
   output logic [1:0]                 m_keep_o,
   output logic                       m_en_o,
   output logic [$clog2(DEPTH):0]     fill_o,
   output logic [1:0]                 err_o,
   input  logic                       err_clr_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] READY_MAX_C = LW'(DEPTH - 2);
   localparam logic [LW-1:0] START_LVL_C = LW'(START_LVL);
   localparam logic [AW-1:0] PTR_ONE_C   = AW'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_STREAM = 2'b01,
      ST_POST   = 2'b10
   } state_t;

   // FIFO entry: {last, data}
   logic [DW:0]      mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [LW-1:0]    level_r;
   logic [LW-1:0]    last_cnt_r;
   state_t           state_r;
   state_t           state_nxt_s;
   logic [2*DW-1:0]  m_data_r;
   logic [2*DW-1:0]  data_nxt_s;
   logic [1:0]       m_keep_r;
   logic [1:0]       keep_nxt_s;
   logic             m_en_r;
   logic             en_nxt_s;
   logic [1:0]       err_r;

   logic             accept_s;
   logic [1:0]       wr_cnt_s;
   logic             wr_last_s;
   logic             keep_err_s;
   logic [DW:0]      head_s;
   logic [DW:0]      sec_s;
   logic [1:0]       avail_s;
   logic [1:0]       rd_cnt_s;
   logic             rd_last_s;
   logic             do_pop_s;
   logic             underrun_s;

   assign s_ready_o = (level_r <= READY_MAX_C);
   assign accept_s  = s_valid_i & s_ready_o;
   assign head_s    = mem_r[rd_ptr_r];
   assign sec_s     = mem_r[rd_ptr_r + PTR_ONE_C];

   assign m_data_o  = m_data_r;
   assign m_keep_o  = m_keep_r;
   assign m_en_o    = m_en_r;
   assign fill_o    = level_r;
   assign err_o     = err_r;

   // Decode the accepted input word into a write count and error/last flags
   always_comb begin
      wr_cnt_s   = 2'd0;
      wr_last_s  = 1'b0;
      keep_err_s = 1'b0;
      if (accept_s) begin
         case (s_keep_i)
            2'b01: begin
               wr_cnt_s  = 2'd1;
               wr_last_s = s_last_i;
            end
            2'b11: begin
               wr_cnt_s  = 2'd2;
               wr_last_s = s_last_i;
            end
            2'b10: begin
               keep_err_s = 1'b1;
            end
            default: begin
               wr_cnt_s = 2'd0;
            end
         endcase
      end else begin
         wr_cnt_s = 2'd0;
      end
   end

   // Beats available for one pop; a head beat with last ends the burst alone
   always_comb begin
      avail_s = 2'd0;
      if (level_r == {LW{1'b0}}) begin
         avail_s = 2'd0;
      end else if ((level_r == LW'(1)) || head_s[DW]) begin
         avail_s = 2'd1;
      end else begin
         avail_s = 2'd2;
      end
   end

   // Burst FSM next state and next output word
   always_comb begin
      state_nxt_s = state_r;
      data_nxt_s  = m_data_r;
      keep_nxt_s  = 2'b00;
      en_nxt_s    = 1'b0;
      do_pop_s    = 1'b0;
      rd_cnt_s    = 2'd0;
      rd_last_s   = 1'b0;
      underrun_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if ((level_r >= START_LVL_C) || (last_cnt_r != {LW{1'b0}})) begin
               do_pop_s = 1'b1;
            end else begin
               do_pop_s = 1'b0;
            end
         end
         ST_STREAM: begin
            do_pop_s = 1'b1;
         end
         ST_POST: begin
            en_nxt_s    = 1'b1;
            data_nxt_s  = {(2*DW){1'b0}};
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      if (do_pop_s) begin
         rd_cnt_s = avail_s;
         en_nxt_s = 1'b1;
         // avail_s == 2 implies the head is not last, so at most one last pops
         rd_last_s = ((avail_s != 2'd0) && head_s[DW]) || ((avail_s == 2'd2) && sec_s[DW]);
         case (avail_s)
            2'd1: begin
               data_nxt_s = {{DW{1'b0}}, head_s[DW-1:0]};
               keep_nxt_s = 2'b01;
            end
            2'd2: begin
               data_nxt_s = {sec_s[DW-1:0], head_s[DW-1:0]};
               keep_nxt_s = 2'b11;
            end
            default: begin
               data_nxt_s = {(2*DW){1'b0}};
               keep_nxt_s = 2'b00;
               underrun_s = 1'b1;
            end
         endcase
         state_nxt_s = rd_last_s ? ST_POST : ST_STREAM;
      end else begin
         rd_cnt_s = 2'd0;
      end
   end

   // FIFO storage; lane0 of a two-beat word never carries last
   always_ff @(posedge clk_sdr_i) begin
      if (wr_cnt_s != 2'd0) begin
         mem_r[wr_ptr_r] <= {(wr_cnt_s == 2'd1) & s_last_i, s_data_i[DW-1:0]};
      end
      if (wr_cnt_s == 2'd2) begin
         mem_r[wr_ptr_r + PTR_ONE_C] <= {s_last_i, s_data_i[2*DW-1:DW]};
      end
   end

   // Pointers, level, last count, FSM state, output word and sticky errors
   always_ff @(posedge clk_sdr_i or negedge rst_sdr_ni) begin
      if (!rst_sdr_ni) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         level_r    <= {LW{1'b0}};
         last_cnt_r <= {LW{1'b0}};
         state_r    <= ST_IDLE;
         m_data_r   <= {(2*DW){1'b0}};
         m_keep_r   <= 2'b00;
         m_en_r     <= 1'b0;
         err_r      <= 2'b00;
      end else begin
         wr_ptr_r   <= wr_ptr_r + AW'(wr_cnt_s);
         rd_ptr_r   <= rd_ptr_r + AW'(rd_cnt_s);
         level_r    <= level_r + LW'(wr_cnt_s) - LW'(rd_cnt_s);
         last_cnt_r <= last_cnt_r + LW'(wr_last_s) - LW'(rd_last_s);
         state_r    <= state_nxt_s;
         m_data_r   <= data_nxt_s;
         m_keep_r   <= keep_nxt_s;
         m_en_r     <= en_nxt_s;
         err_r      <= (err_clr_i ? 2'b00 : err_r) | {underrun_s, keep_err_s};
      end
   end

endmodule
